// File: rtl/ides4_align.sv
// ides4_align: word-alignment controller for a 4:1 DDR input deserialiser.
// Registers the parallel word, hunts for TRAIN_WORD by issuing bit-slip
// (CALIB) pulses, and reports lock / failure to the capture logic.
//
// Optional feature macro: IDES4_ALIGN_MONITOR_EN
//   defined   : LOCKED counts mismatches into err_cnt_o and 4 consecutive
//               mismatches restart alignment (err_cnt_o retained).
//   undefined : err_cnt_o tied to 0, LOCKED never drops.
//
// Ports:
//   PCLK      in   slow (parallel) clock
//   RESET     in   asynchronous, active-high reset
//   start_i   in   single-cycle (re)start request
//   q_i       in   [3:0] parallel word {Q3,Q2,Q1,Q0}
//   calib_o   out  bit-slip pulse to the deserialiser CALIB input
//   data_o    out  [3:0] q_i registered
//   valid_o   out  high while locked
//   locked_o  out  alignment achieved
//   fail_o    out  alignment exhausted without lock
//   slips_o   out  [5:0] slips issued since last start (saturating)
//   err_cnt_o out  [7:0] locked-state mismatch count (saturating)
module ides4_align #(
  parameter logic [3:0]  TRAIN_WORD  = 4'b1100,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned MATCH_COUNT = 8,
  parameter int unsigned MAX_REVS    = 2
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       start_i,
  input  logic [3:0] q_i,
  output logic       calib_o,
  output logic [3:0] data_o,
  output logic       valid_o,
  output logic       locked_o,
  output logic       fail_o,
  output logic [5:0] slips_o,
  output logic [7:0] err_cnt_o
);

  localparam int unsigned Q_W        = 4;
  localparam int unsigned SETTLE_W   = 4;
  localparam int unsigned MATCH_W    = 8;
  localparam int unsigned SLIP_W     = 6;
  localparam int unsigned SLIP_LIMIT = 4 * MAX_REVS;

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT);
  localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(SLIP_LIMIT);
  localparam logic [SLIP_W-1:0]   SLIP_SAT    = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [Q_W-1:0]      q_r;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [SLIP_W-1:0]   slips_q, slips_d;
  logic                word_match;
  logic                mon_restart;

  assign word_match = (q_r == TRAIN_WORD);

  // Input word register; every comparison uses this registered copy.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      q_r <= '0;
    end else begin
      q_r <= q_i;
    end
  end

  // State and alignment counters.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      match_q  <= '0;
      slips_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      slips_q  <= slips_d;
    end
  end

  // Next-state logic; a start (or a monitor-triggered restart) overrides
  // whatever decision the current state would make.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slips_d  = slips_q;
    if (start_i || mon_restart) begin
      state_d  = ST_SETTLE;
      settle_d = SETTLE_LOAD;
      match_d  = '0;
      slips_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_d = ST_CHECK;
          end else begin
            settle_d = settle_q - SETTLE_W'(1);
          end
        end
        ST_CHECK: begin
          if (word_match) begin
            if (match_q != '1) begin
              match_d = match_q + MATCH_W'(1);
            end
            if (match_d == MATCH_LAST) begin
              state_d = ST_LOCKED;
            end
          end else begin
            match_d = '0;
            if (slips_q == SLIP_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          if (slips_q != SLIP_SAT) begin
            slips_d = slips_q + SLIP_W'(1);
          end
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef IDES4_ALIGN_MONITOR_EN
  localparam int unsigned ERR_W = 8;
  localparam int unsigned MIS_W = 2;

  logic [ERR_W-1:0] err_q, err_d;
  logic [MIS_W-1:0] mis_q, mis_d;

  // Fourth consecutive mismatch while locked restarts alignment.
  assign mon_restart = (state_q == ST_LOCKED) && !word_match && (mis_q == MIS_W'(3));

  // Locked-state error count and consecutive-mismatch run length.
  always_comb begin
    err_d = err_q;
    mis_d = mis_q;
    if (start_i) begin
      err_d = '0;
      mis_d = '0;
    end else if (state_q != ST_LOCKED) begin
      mis_d = '0;
    end else if (!word_match) begin
      if (err_q != '1) begin
        err_d = err_q + ERR_W'(1);
      end
      mis_d = mon_restart ? '0 : (mis_q + MIS_W'(1));
    end else begin
      mis_d = '0;
    end
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      err_q <= '0;
      mis_q <= '0;
    end else begin
      err_q <= err_d;
      mis_q <= mis_d;
    end
  end

  assign err_cnt_o = err_q;
`else
  assign mon_restart = 1'b0;
  assign err_cnt_o   = '0;
`endif

  // Outputs decode directly from registers so calib_o drops with RESET.
  assign calib_o  = (state_q == ST_SLIP);
  assign locked_o = (state_q == ST_LOCKED);
  assign valid_o  = (state_q == ST_LOCKED);
  assign fail_o   = (state_q == ST_FAIL);
  assign data_o   = q_r;
  assign slips_o  = slips_q;

endmodule
